branch_redirect_ctrl: RTL and testbench

- Sequences control-flow redirects for the two-slot VLIW execute stage.
- Resolves the branch condition for each slot, picks the oldest taken slot and holds a redirect that was resolved under stall.
- Issues one registered redirect to the fetch PC mux, then drives a multi-cycle flush of wrong-path bundles.
- Sits between execute-stage operand forwarding and the fetch/decode pipeline registers.

---
 rtl/branch_redirect_ctrl.sv | 171 +++++++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// Branch resolve and redirect/flush sequencer for the two-slot VLIW execute stage.
// Optional perf counters are enabled by defining BRANCH_PERF_CNT_EN.
module branch_redirect_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              stall,
  input  logic [2:0]        s0_kind,
  input  logic [31:0]       s0_op1,
  input  logic [31:0]       s0_op2,
  input  logic [ADDR_W-1:0] s0_target,
  input  logic [2:0]        s1_kind,
  input  logic [31:0]       s1_op1,
  input  logic [31:0]       s1_op2,
  input  logic [ADDR_W-1:0] s1_target,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic              busy
`ifdef BRANCH_PERF_CNT_EN
  ,
  output logic [31:0]       taken_cnt,
  output logic [31:0]       deferred_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [3:0] FL_INIT = 4'(FLUSH_CYCLES - 1);

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic [ADDR_W-1:0]   pend_q;
  logic                rv_q;
  logic [ADDR_W-1:0]   pc_q;
  logic                flush_q;
  logic                busy_q;

  logic                t0;
  logic                t1;
  logic                br_taken;
  logic [ADDR_W-1:0]   br_tgt;
  logic                issue;
  logic                defer;

  function automatic logic slot_taken(
    input logic [2:0]  kind,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic eq;
    logic lt;
    eq = (a == b);
    lt = ($signed(a) < $signed(b));
    case (kind)
      3'd1:    slot_taken = eq;
      3'd2:    slot_taken = ~eq;
      3'd3:    slot_taken = lt;
      3'd4:    slot_taken = ~lt;
      3'd5:    slot_taken = 1'b1;
      default: slot_taken = 1'b0;
    endcase
  endfunction

  // slot0 is the older instruction, so it wins when both resolve taken
  always_comb begin
    t0       = slot_taken(s0_kind, s0_op1, s0_op2);
    t1       = slot_taken(s1_kind, s1_op1, s1_op2);
    br_taken = t0 | t1;
    br_tgt   = t0 ? s0_target : s1_target;
    issue    = 1'b0;
    defer    = 1'b0;
    unique case (state_q)
      IDLE: begin
        issue = br_taken & ~stall;
        defer = br_taken & stall;
      end
      PEND:    issue = ~stall;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      rv_q    <= 1'b0;
      pc_q    <= '0;
      flush_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      pc_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (issue) begin
            state_q <= FLUSH;
            cnt_q   <= FL_INIT;
            rv_q    <= 1'b1;
            pc_q    <= br_tgt;
            flush_q <= 1'b1;
            busy_q  <= 1'b1;
          end else if (defer) begin
            state_q <= PEND;
            pend_q  <= br_tgt;
            flush_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            flush_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        PEND: begin
          busy_q <= 1'b1;
          if (issue) begin
            state_q <= FLUSH;
            cnt_q   <= FL_INIT;
            rv_q    <= 1'b1;
            pc_q    <= pend_q;
            flush_q <= 1'b1;
          end
        end
        FLUSH: begin
          if (cnt_q == 4'd0) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          flush_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign redirect_valid = rv_q;
  assign redirect_pc    = pc_q;
  assign flush          = flush_q;
  assign busy           = busy_q;

`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] taken_cnt_q;
  logic [31:0] deferred_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      taken_cnt_q    <= '0;
      deferred_cnt_q <= '0;
    end else begin
      if (issue) taken_cnt_q <= taken_cnt_q + 32'd1;
      if (defer) deferred_cnt_q <= deferred_cnt_q + 32'd1;
    end
  end

  assign taken_cnt    = taken_cnt_q;
  assign deferred_cnt = deferred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Table-driven scoreboard bench for branch_redirect_ctrl.
module tb_branch_redirect_ctrl;

  logic        clk;
  logic        rstn;
  logic        stall;
  logic [2:0]  s0_kind;
  logic [31:0] s0_op1;
  logic [31:0] s0_op2;
  logic [31:0] s0_target;
  logic [2:0]  s1_kind;
  logic [31:0] s1_op1;
  logic [31:0] s1_op2;
  logic [31:0] s1_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        busy;
`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] taken_cnt;
  logic [31:0] deferred_cnt;
`endif

  branch_redirect_ctrl #(
    .ADDR_W(32),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .stall(stall),
    .s0_kind(s0_kind),
    .s0_op1(s0_op1),
    .s0_op2(s0_op2),
    .s0_target(s0_target),
    .s1_kind(s1_kind),
    .s1_op1(s1_op1),
    .s1_op2(s1_op2),
    .s1_target(s1_target),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .flush(flush),
    .busy(busy)
`ifdef BRANCH_PERF_CNT_EN
    ,
    .taken_cnt(taken_cnt),
    .deferred_cnt(deferred_cnt)
`endif
  );

  typedef struct {
    logic        stall;
    logic [2:0]  k0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [31:0] t0;
    logic [2:0]  k1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [31:0] t1;
    logic        rv;
    logic [31:0] pc;
    logic        fl;
    logic        bz;
  } vec_t;

  typedef struct {
    logic        rv;
    logic [31:0] pc;
    logic        fl;
    logic        bz;
  } exp_t;

  localparam int NV = 22;
  vec_t vt[NV];
  exp_t q[$];
  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic st,
    input logic [2:0] k0, input logic [31:0] a0,
    input logic [31:0] b0, input logic [31:0] t0,
    input logic [2:0] k1, input logic [31:0] a1,
    input logic [31:0] b1, input logic [31:0] t1,
    input logic rv, input logic [31:0] pc,
    input logic fl, input logic bz
  );
    vec_t v;
    v.stall = st;
    v.k0 = k0; v.a0 = a0; v.b0 = b0; v.t0 = t0;
    v.k1 = k1; v.a1 = a1; v.b1 = b1; v.t1 = t1;
    v.rv = rv; v.pc = pc; v.fl = fl; v.bz = bz;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    stall = v.stall;
    s0_kind = v.k0; s0_op1 = v.a0; s0_op2 = v.b0; s0_target = v.t0;
    s1_kind = v.k1; s1_op1 = v.a1; s1_op2 = v.b1; s1_target = v.t1;
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, ".rv"}, 32'(redirect_valid), 32'(e.rv));
    chk({tag, ".flush"}, 32'(flush), 32'(e.fl));
    chk({tag, ".busy"}, 32'(busy), 32'(e.bz));
    if (e.rv) chk({tag, ".pc"}, redirect_pc, e.pc);
  endtask

  vec_t none;

  initial begin
    exp_t e;
    exp_t z;
    z.rv = 0; z.pc = 0; z.fl = 0; z.bz = 0;
    none = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    vt[0]  = mk(0, 1, 5, 5, 32'h100, 0, 0, 0, 0, 1, 32'h100, 1, 1);
    vt[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    vt[2]  = none;
    vt[3]  = mk(0, 3, 32'hFFFFFFFF, 1, 32'h40, 0, 0, 0, 0, 1, 32'h40, 1, 1);
    vt[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    vt[5]  = none;
    vt[6]  = mk(0, 4, 32'hFFFFFFFF, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[7]  = none;
    vt[8]  = mk(0, 5, 0, 0, 32'h200, 2, 3, 4, 32'h300, 1, 32'h200, 1, 1);
    vt[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    vt[10] = none;
    vt[11] = mk(1, 0, 0, 0, 0, 1, 7, 7, 32'h80, 0, 0, 0, 1);
    vt[12] = mk(1, 0, 0, 0, 0, 1, 7, 7, 32'h999, 0, 0, 0, 1);
    vt[13] = mk(1, 5, 0, 0, 32'h444, 1, 7, 7, 32'h80, 0, 0, 0, 1);
    vt[14] = mk(0, 0, 0, 0, 0, 1, 7, 7, 32'h80, 1, 32'h80, 1, 1);
    vt[15] = mk(0, 5, 0, 0, 32'h500, 0, 0, 0, 0, 0, 0, 1, 1);
    vt[16] = mk(0, 5, 0, 0, 32'h500, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[17] = mk(0, 6, 5, 5, 32'h10, 7, 5, 5, 32'h20, 0, 0, 0, 0);
    vt[18] = mk(0, 2, 5, 5, 32'h30, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[19] = mk(0, 4, 1, 32'hFFFFFFFF, 32'h50, 0, 0, 0, 0, 1, 32'h50, 1, 1);
    vt[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    vt[21] = none;

    rstn = 1'b0;
    drive(none);
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", z);
    chk("reset.pc", redirect_pc, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      drive(vt[i]);
      e.rv = vt[i].rv; e.pc = vt[i].pc;
      e.fl = vt[i].fl; e.bz = vt[i].bz;
      q.push_back(e);
      @(posedge clk);
      #1;
      e = q.pop_front();
      check_out($sformatf("vec%0d", i), e);
    end

`ifdef BRANCH_PERF_CNT_EN
    chk("taken_cnt", taken_cnt, 32'd5);
    chk("deferred_cnt", deferred_cnt, 32'd1);
`endif

    // Reset asserted in the middle of a flush
    drive(mk(0, 5, 0, 0, 32'h700, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    e.rv = 1; e.pc = 32'h700; e.fl = 1; e.bz = 1;
    check_out("rst_pre", e);
    drive(none);
    #2;
    rstn = 1'b0;
    #1;
    check_out("rst_mid", z);
    chk("rst_mid.pc", redirect_pc, 32'h0);
`ifdef BRANCH_PERF_CNT_EN
    chk("rst_taken_cnt", taken_cnt, 32'd0);
`endif
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check_out("rst_idle", z);

    drive(mk(0, 1, 9, 9, 32'h900, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    e.rv = 1; e.pc = 32'h900; e.fl = 1; e.bz = 1;
    check_out("post_rst", e);
    drive(none);
    repeat (2) @(posedge clk);
    #1;
    check_out("post_idle", z);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
